// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush-to-bubble and a saturating stall counter.
module pipeline_skid_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 acc;
  logic                 take;

  // Handshake outputs decode from state only, so out_ready never reaches in_ready.
  assign in_ready    = (state_q != ST_FULL);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_q;
  assign stall_count = stall_cnt_q;
  assign acc         = in_valid && in_ready;
  assign take        = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (acc && take) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (take) begin
            // main keeps its last value while the stage is empty
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= FLUSH_VALUE;
      skid_q      <= FLUSH_VALUE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
